sha256_v1_0_s00_axi: RTL and testbench

SHA256_V1_0_S00_AXI -- requirements
Module: sha256_v1_0_s00_axi

---
 rtl/sha256_v1_0_s00_axi.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_sha256_v1_0_s00_axi.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_v1_0_s00_axi.sv
// AXI4-Lite SHA-256 engine: SCRATCH, DATA, CTRL/STATUS and DIGEST registers, one round per clock.
// Defining SHA256_IRQ_EN adds a one-cycle completion interrupt output irq.
module sha256_v1_0_s00_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
`ifdef SHA256_IRQ_EN
    ,
    output logic                              irq
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FINAL = 2'd3
    } state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] scratch_q, scratch_d;
    logic [4:0]  count_q, count_d;
    logic [2:0]  ptr_q, ptr_d;
    logic        dv_q, dv_d;
    logic        irq_q, irq_d;
    state_t      state_q, state_d;
    logic [5:0]  round_q, round_d;
    logic [31:0] h_q [8];
    logic [31:0] h_d [8];
    logic [31:0] v_q [8];
    logic [31:0] v_d [8];
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];

    logic        busy_s;
    logic        wr_en_s;
    logic [1:0]  wr_sel_s;
    logic [1:0]  rd_sel_s;
    logic [31:0] t1_s, t2_s, w_new_s;
    logic [31:0] rd_word_s;
    logic        unused_s;

    assign busy_s   = (state_q != ST_IDLE);
    assign wr_en_s  = awready_q & wready_q;
    assign wr_sel_s = S_AXI_AWADDR[3:2];
    assign rd_sel_s = S_AXI_ARADDR[3:2];
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // w_q[0] always holds W[t]; the window slides by one word per round
    assign t1_s    = v_q[7] + big_sigma1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + K[round_q] + w_q[0];
    assign t2_s    = big_sigma0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
    assign w_new_s = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

    // Next-state logic for the AXI handshakes, register file and compression FSM
    always_comb begin
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        dv_d      = dv_q;
        irq_d     = 1'b0;
        state_d   = state_q;
        round_d   = round_q;
        h_d       = h_q;
        v_d       = v_q;
        w_d       = w_q;
        rd_word_s = 32'h0000_0000;

        awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & ~bvalid_q;
        wready_d  = S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & ~bvalid_q;
        arready_d = S_AXI_ARVALID & ~arready_q & ~rvalid_q;

        if (wr_en_s) begin
            bvalid_d = 1'b1;
        end else if (S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end

        if (arready_q) begin
            rvalid_d = 1'b1;
        end else if (S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end

        case (rd_sel_s)
            2'd0:    rd_word_s = scratch_q;
            2'd1:    rd_word_s = {27'h0, count_q};
            2'd2:    rd_word_s = {23'h0, count_q, 2'b00, dv_q, busy_s};
            2'd3:    rd_word_s = busy_s ? 32'h0000_0000 : h_q[ptr_q];
            default: rd_word_s = 32'h0000_0000;
        endcase

        if (arready_q) begin
            rdata_d = rd_word_s;
            if ((rd_sel_s == 2'd3) && !busy_s) begin
                ptr_d = ptr_q + 3'd1;
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            rdata_d = rdata_q;
        end

        if (wr_en_s) begin
            case (wr_sel_s)
                2'd0: begin
                    for (int b = 0; b < 4; b++) begin
                        if (S_AXI_WSTRB[b]) begin
                            scratch_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
                        end else begin
                            scratch_d[8*b +: 8] = scratch_q[8*b +: 8];
                        end
                    end
                end
                2'd1: begin
                    if ((|S_AXI_WSTRB) && (count_q != 5'd16) && !busy_s) begin
                        w_d[count_q[3:0]] = S_AXI_WDATA;
                        count_d = count_q + 5'd1;
                    end else begin
                        count_d = count_q;
                    end
                end
                2'd2: begin
                    // START (bit0) wins over NEXT (bit1); both need a full block and an idle core
                    if (!busy_s && (count_q == 5'd16) && (S_AXI_WDATA[1:0] != 2'b00)) begin
                        if (S_AXI_WDATA[0]) begin
                            h_d = IV;
                        end else begin
                            h_d = h_q;
                        end
                        dv_d    = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        case (state_q)
            ST_LOAD: begin
                v_d     = h_q;
                round_d = 6'd0;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i+1];
                end
                w_d[15] = w_new_s;
                v_d[0]  = t1_s + t2_s;
                v_d[1]  = v_q[0];
                v_d[2]  = v_q[1];
                v_d[3]  = v_q[2];
                v_d[4]  = v_q[3] + t1_s;
                v_d[5]  = v_q[4];
                v_d[6]  = v_q[5];
                v_d[7]  = v_q[6];
                round_d = round_q + 6'd1;
                if (round_q == 6'd63) begin
                    state_d = ST_FINAL;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + v_q[i];
                end
                dv_d    = 1'b1;
                irq_d   = 1'b1;
                count_d = 5'd0;
                ptr_d   = 3'd0;
                state_d = ST_IDLE;
            end
            default: begin
                round_d = round_q;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any hash in flight
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0000_0000;
            scratch_q <= 32'h0000_0000;
            count_q   <= 5'd0;
            ptr_q     <= 3'd0;
            dv_q      <= 1'b0;
            irq_q     <= 1'b0;
            state_q   <= ST_IDLE;
            round_q   <= 6'd0;
            h_q       <= IV;
            v_q       <= '{default: 32'h0000_0000};
            w_q       <= '{default: 32'h0000_0000};
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            dv_q      <= dv_d;
            irq_q     <= irq_d;
            state_q   <= state_d;
            round_q   <= round_d;
            h_q       <= h_d;
            v_q       <= v_d;
            w_q       <= w_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;

`ifdef SHA256_IRQ_EN
    assign irq = irq_q;
`else
    logic unused_irq_s;
    assign unused_irq_s = irq_q;
`endif

endmodule

// File: tb/tb_sha256_v1_0_s00_axi.sv
// Scoreboard bench for sha256_v1_0_s00_axi: a register/SHA-256 reference model predicts every response.
module tb_sha256_v1_0_s00_axi;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
`ifdef SHA256_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    sha256_v1_0_s00_axi dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
`ifdef SHA256_IRQ_EN
        , .irq(irq)
`endif
    );

    localparam logic [31:0] TB_IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] TB_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] ABC_DIGEST [8] = '{
        32'hBA7816BF, 32'h8F01CFEA, 32'h414140DE, 32'h5DAE2223,
        32'hB00361A3, 32'h96177A9C, 32'hB410FF61, 32'hF20015AD
    };

    typedef struct {
        logic [31:0] data;
        bit          chk;
        string       name;
    } rexp_t;

    rexp_t      rd_q [$];
    logic [1:0] wr_q [$];
    int         checks = 0;
    int         errors = 0;

    // Reference model state
    logic [31:0] m_scratch;
    logic [4:0]  m_count;
    logic [2:0]  m_ptr;
    bit          m_busy, m_dv;
    logic [31:0] m_blk [16];
    logic [31:0] m_h [8];
    logic [31:0] m_h_next [8];

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] y;
        y = {x, x} >> n;
        return y[31:0];
    endfunction

    task automatic ref_compress();
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = m_blk[t];
            end else begin
                s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = w[t-16] + s0 + w[t-7] + s1;
            end
        end
        a = m_h[0]; b = m_h[1]; c = m_h[2]; d = m_h[3];
        e = m_h[4]; f = m_h[5]; g = m_h[6]; h = m_h[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + TB_K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        m_h_next[0] = m_h[0] + a; m_h_next[1] = m_h[1] + b;
        m_h_next[2] = m_h[2] + c; m_h_next[3] = m_h[3] + d;
        m_h_next[4] = m_h[4] + e; m_h_next[5] = m_h[5] + f;
        m_h_next[6] = m_h[6] + g; m_h_next[7] = m_h[7] + h;
    endtask

    task automatic model_reset();
        m_scratch = 32'h0; m_count = 5'd0; m_ptr = 3'd0; m_busy = 1'b0; m_dv = 1'b0;
        m_h = TB_IV;
    endtask

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        case (addr[3:2])
            2'd0: for (int b = 0; b < 4; b++) if (strb[b]) m_scratch[8*b +: 8] = data[8*b +: 8];
            2'd1: if (strb != 4'h0 && m_count < 5'd16 && !m_busy) begin
                      m_blk[m_count[3:0]] = data;
                      m_count = m_count + 5'd1;
                  end
            2'd2: if (!m_busy && m_count == 5'd16 && data[1:0] != 2'b00) begin
                      if (data[0]) m_h = TB_IV;
                      ref_compress();
                      m_busy = 1'b1;
                      m_dv = 1'b0;
                  end
            default: ;
        endcase
    endtask

    task automatic model_finish();
        m_h = m_h_next; m_busy = 1'b0; m_dv = 1'b1; m_count = 5'd0; m_ptr = 3'd0;
    endtask

    task automatic model_read(input logic [3:0] addr, output logic [31:0] v);
        case (addr[3:2])
            2'd0: v = m_scratch;
            2'd1: v = {27'h0, m_count};
            2'd2: v = {23'h0, m_count, 2'b00, m_dv, m_busy};
            default: begin
                if (m_busy) begin
                    v = 32'h0;
                end else begin
                    v = m_h[m_ptr];
                    m_ptr = m_ptr + 3'd1;
                end
            end
        endcase
    endtask

    // Monitor: pops the scoreboard on every completed write-response and read-data handshake
    always @(negedge clk) begin
        if (bvalid && bready) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL bresp_unexpected got %b with no write pending", bresp);
            end else begin
                logic [1:0] eb;
                eb = wr_q.pop_front();
                if (bresp !== eb) begin
                    errors++;
                    $display("FAIL bresp got %b exp %b", bresp, eb);
                end
            end
        end
        if (rvalid && rready) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdata_unexpected got %h with no read pending", rdata);
            end else begin
                rexp_t e;
                e = rd_q.pop_front();
                if (e.chk) begin
                    checks++;
                    if (rdata !== e.data || rresp !== 2'b00) begin
                        errors++;
                        $display("FAIL %s got %h rresp %b exp %h rresp 00", e.name, rdata, rresp, e.data);
                    end
                end
            end
        end
    end

    task automatic timeout(input string what);
        checks++;
        errors++;
        $display("FAIL %s timeout got no handshake exp handshake within 50 cycles", what);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        model_write(addr, data, strb);
        wr_q.push_back(2'b00);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 50);
        if (!awready) timeout("awready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!bvalid) timeout("bvalid");
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input bit chk,
                            input string name, output logic [31:0] d);
        int n;
        rexp_t e;
        e.data = exp; e.chk = chk; e.name = name;
        rd_q.push_back(e);
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 50);
        if (!arready) timeout("arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!rvalid) timeout("rvalid");
        d = rdata;
        @(posedge clk); #1;
    endtask

    task automatic check_read(input logic [3:0] addr, input string name);
        logic [31:0] exp, d;
        model_read(addr, exp);
        axi_read(addr, exp, 1'b1, name, d);
    endtask

    task automatic wait_done();
        int n;
        logic [31:0] d;
        n = 0; d = 32'h1;
        while (d[0] && n < 100) begin
            axi_read(4'h8, 32'h0, 1'b0, "poll", d);
            n++;
        end
        checks++;
        if (d[0]) begin
            errors++;
            $display("FAIL busy_clear got busy=1 exp busy=0 after %0d polls", n);
        end
        model_finish();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdy/vld %b rdata %h exp 00000 00000000",
                     {awready, wready, bvalid, arready, rvalid}, rdata);
        end
        areset = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic read_digest8(input string name);
        for (int i = 0; i < 8; i++) check_read(4'hC, name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, tmp;
        areset = 1'b1; awaddr = 4'h0; araddr = 4'h0; awprot = 3'h0; arprot = 3'h0;
        awvalid = 1'b0; wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
        arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        do_reset();

        check_read(4'h0, "rst_scratch");
        check_read(4'h4, "rst_count");
        check_read(4'h8, "rst_status");
        check_read(4'hC, "rst_digest0");
        check_read(4'hC, "rst_digest1");

        axi_write(4'h0, 32'hFFFFFFFF, 4'b0101);
        check_read(4'h0, "scratch_strb");
        axi_write(4'h1, 32'h00000BAD, 4'hF);
        check_read(4'h1, "scratch_bad");
        for (int i = 0; i < 4; i++) begin
            axi_write({2'b00, 2'($urandom_range(0, 3))}, $urandom, 4'($urandom_range(0, 15)));
            check_read({2'b00, 2'($urandom_range(0, 3))}, "scratch_rand");
        end

        // "abc" single block against the published digest
        axi_write(4'h4, 32'h61626380, 4'hF);
        for (int i = 0; i < 14; i++) axi_write(4'h4, 32'h0, 4'hF);
        axi_write(4'h4, 32'h00000018, 4'hF);
        check_read(4'h4, "abc_count");
        axi_write(4'h8, 32'h1, 4'hF);
        check_read(4'h8, "abc_status_busy");
        check_read(4'hC, "digest_while_busy");
        axi_write(4'h4, 32'h12345678, 4'hF);
        wait_done();
        check_read(4'h8, "abc_status_done");
        for (int i = 0; i < 8; i++) begin
            model_read(4'hC, tmp);
            axi_read(4'hC, ABC_DIGEST[i], 1'b1, "abc_digest", d);
        end
        model_read(4'hC, tmp);
        axi_read(4'hC, ABC_DIGEST[0], 1'b1, "digest_wrap", d);

        // Overfill, zero strobe, then NEXT continues from the abc state
        axi_write(4'h4, $urandom, 4'h0);
        for (int i = 0; i < 17; i++) axi_write(4'h4, $urandom, 4'($urandom_range(1, 15)));
        check_read(4'h4, "count_sat");
        axi_write(4'h8, 32'h2, 4'hF);
        check_read(4'h8, "next_status_busy");
        wait_done();
        read_digest8("next_digest");

        // START refused with a partial block, then START beats NEXT when both set
        for (int i = 0; i < 5; i++) axi_write(4'h4, $urandom, 4'hF);
        axi_write(4'h8, 32'h1, 4'hF);
        check_read(4'h8, "start_partial");
        for (int i = 0; i < 11; i++) axi_write(4'h4, $urandom, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        wait_done();
        check_read(4'h8, "prio_status");
        read_digest8("prio_digest");

        // Reset in the middle of a hash
        axi_write(4'h0, $urandom, 4'hF);
        for (int i = 0; i < 16; i++) axi_write(4'h4, $urandom, 4'hF);
        axi_write(4'h8, 32'h1, 4'hF);
        check_read(4'h8, "mid_status_busy");
        do_reset();
        check_read(4'h8, "abort_status");
        check_read(4'h0, "abort_scratch");
        check_read(4'hC, "abort_digest0");

        repeat (4) @(posedge clk);
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d reads %0d writes pending exp 0", rd_q.size(), wr_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
